instr_fetch_unit: RTL and testbench



---
 rtl/rv_fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/instr_fetch_unit.sv | 69 ++++++
 tb/tb_instr_fetch_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the rv32im fetch front end.
package rv_fetch_pkg;

   localparam logic [31:0] INSTR_BYTES = 32'd4;
   localparam logic [31:0] RV_NOP      = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instr} entries; head is read from storage registers.
// Push/pop are issued only when legal by the owner; flush drops every entry in one cycle.
module fetch_fifo
   import rv_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          push,
   input  fetch_entry_t  push_data,
   input  logic          pop,
   output fetch_entry_t  head_data,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   fetch_entry_t mem [DEPTH];
   fetch_entry_t last_head;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // Once drained, the head keeps showing the last entry that was visible.
   assign head_data = empty ? last_head : mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         last_head <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (!empty) begin
            last_head <= mem[rd_ptr];
         end
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) begin
               mem[wr_ptr] <= push_data;
               wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC owner and fetch stage: one word per cycle into a buffer toward decode, 1-cycle fetch-to-decode.
// PC freezes while the buffer is full and not popping; a redirect flushes the buffer and reloads PC.
module instr_fetch_unit
   import rv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [31:0]   pc;
   logic          push;
   logic          pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count_unused;
   fetch_entry_t  push_data;
   fetch_entry_t  head_data;

   assign pop  = out_valid & out_ready;
   // Full is fine to push into only when the head leaves in the same cycle.
   assign push = fetch_en & ~redirect_valid & (~fifo_full | pop);

   assign push_data = '{pc: pc, instr: imem_rdata};
   assign imem_addr = pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (redirect_valid) begin
         pc <= redirect_pc & ~32'h3;
      end else if (push) begin
         pc <= pc + INSTR_BYTES;
      end
   end

   fetch_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head_data (head_data),
      .count     (fifo_count_unused),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign out_valid = ~fifo_empty;
   assign out_pc    = head_data.pc;
   assign out_instr = head_data.instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + random bench for instr_fetch_unit with a queue scoreboard of expected decode entries.
module tb_instr_fetch_unit;
   import rv_fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          DEPTH  = 2;

   logic        clk;
   logic        reset;
   logic        fetch_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;

   int n_chk  = 0;
   int n_fail = 0;

   fetch_entry_t sb[$];
   logic [31:0]  mpc;
   logic [31:0]  addr_hold;

   function automatic logic [31:0] word(input logic [31:0] a);
      return 32'h1000_0000 + (a >> 2);
   endfunction

   assign imem_rdata = word(imem_addr);

   instr_fetch_unit #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_en       (fetch_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("sb_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
      chk("sb_addr", imem_addr, mpc);
      if (sb.size() != 0) begin
         chk("sb_pc", out_pc, sb[0].pc);
         chk("sb_instr", out_instr, sb[0].instr);
      end
   endtask

   // One clock with the currently driven inputs; the model advances on the edge.
   task automatic cycle();
      logic        m_pop;
      logic        m_push;
      logic        m_redir;
      logic [31:0] m_tgt;
      m_pop   = (sb.size() != 0) && out_ready;
      m_push  = fetch_en && !redirect_valid && ((sb.size() < DEPTH) || m_pop);
      m_redir = redirect_valid;
      m_tgt   = {redirect_pc[31:2], 2'b00};
      @(posedge clk);
      if (m_redir) begin
         sb.delete();
         mpc = m_tgt;
      end else begin
         if (m_pop) void'(sb.pop_front());
         if (m_push) begin
            sb.push_back('{pc: mpc, instr: word(mpc)});
            mpc = mpc + 32'd4;
         end
      end
      @(negedge clk);
      check_model();
   endtask

   initial begin
      reset          = 1'b1;
      fetch_en       = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      mpc            = RST_PC;
      addr_hold      = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_pc", out_pc, 32'd0);
      chk("rst_instr", out_instr, 32'd0);

      // Streaming from reset
      reset     = 1'b0;
      fetch_en  = 1'b1;
      out_ready = 1'b1;
      cycle();
      chk("t1_valid", {31'd0, out_valid}, 32'd1);
      chk("t1_pc0", out_pc, 32'h0);
      chk("t1_instr0", out_instr, 32'h1000_0000);
      repeat (5) cycle();
      chk("t1_pc5", out_pc, 32'h14);
      chk("t1_instr5", out_instr, 32'h1000_0005);

      // Backpressure: buffer fills, PC freezes, head holds
      out_ready = 1'b0;
      repeat (5) cycle();
      chk("t2_hold_pc", out_pc, 32'h14);
      chk("t2_hold_instr", out_instr, 32'h1000_0005);
      chk("t2_freeze_addr", imem_addr, 32'h1C);
      out_ready = 1'b1;
      repeat (3) cycle();
      chk("t2_resume_pc", out_pc, 32'h20);

      // Redirect while full
      out_ready = 1'b0;
      repeat (2) cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      cycle();
      chk("t3_flush_valid", {31'd0, out_valid}, 32'd0);
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      cycle();
      chk("t3_tgt_pc", out_pc, 32'h40);
      chk("t3_tgt_instr", out_instr, 32'h1000_0010);

      // Misaligned target and address wrap
      redirect_valid = 1'b1;
      redirect_pc    = 32'h43;
      cycle();
      chk("t4_align", imem_addr, 32'h40);
      redirect_pc = 32'hFFFF_FFFC;
      cycle();
      chk("t4_top_addr", imem_addr, 32'hFFFF_FFFC);
      redirect_valid = 1'b0;
      cycle();
      chk("t4_wrap_addr", imem_addr, 32'h0);
      chk("t4_top_pc", out_pc, 32'hFFFF_FFFC);
      chk("t4_top_instr", out_instr, 32'h4FFF_FFFF);
      cycle();
      chk("t4_wrap_pc", out_pc, 32'h0);

      // fetch_en low drains the buffer and holds the PC
      out_ready = 1'b0;
      repeat (2) cycle();
      addr_hold = mpc;
      fetch_en  = 1'b0;
      out_ready = 1'b1;
      cycle();
      chk("t5_drain1", {31'd0, out_valid}, 32'd1);
      cycle();
      chk("t5_drained", {31'd0, out_valid}, 32'd0);
      chk("t5_addr_hold", imem_addr, addr_hold);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h80;
      cycle();
      redirect_valid = 1'b0;
      chk("t5_redir_noen", imem_addr, 32'h80);
      cycle();
      chk("t5_noen_valid", {31'd0, out_valid}, 32'd0);

      // Random backpressure, enables and redirects
      for (int i = 0; i < 80; i++) begin
         fetch_en       = ($urandom_range(0, 3) != 0);
         out_ready      = ($urandom_range(0, 2) != 0);
         redirect_valid = ($urandom_range(0, 11) == 0);
         redirect_pc    = 32'($urandom_range(0, 1023));
         cycle();
      end

      // Asynchronous reset between edges
      redirect_valid = 1'b0;
      fetch_en       = 1'b1;
      out_ready      = 1'b1;
      repeat (3) cycle();
      #2 reset = 1'b1;
      #1;
      chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
      chk("t6_async_addr", imem_addr, RST_PC);
      sb.delete();
      mpc = RST_PC;
      @(negedge clk);
      reset = 1'b0;
      cycle();
      chk("t6_restart_pc", out_pc, RST_PC);
      chk("t6_restart_instr", out_instr, 32'h1000_0000);
      repeat (3) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
